pc_step_unit: RTL and testbench

PC_STEP_UNIT -- requirements
Module: pc_step_unit

---
 rtl/pc_step_pkg.sv | 34 +++
 rtl/pc_step_unit_rise_detect.sv | 26 ++
 rtl/pc_step_unit.sv | 132 +++++++++++++
 tb/tb_pc_step_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_step_pkg.sv
// Shared types and constants for the instruction-step PC unit.
package pc_step_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_WAIT_LOW = 2'd2,
      ST_HALTED   = 2'd3
   } state_e;

   localparam logic [31:0] PC_STEP      = 32'd4;
   localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

   // Target for one step: jump beats branch beats sequential; a syscall always
   // falls through so the halted PC points past it.
   function automatic logic [31:0] next_pc(
      input logic [31:0] pc,
      input logic        syscall,
      input logic [15:0] imm16,
      input logic        br,
      input logic        jmp,
      input logic [31:0] jaddr
   );
      logic [31:0] seq;
      logic [31:0] offs;
      seq  = pc + PC_STEP;
      offs = {{14{imm16[15]}}, imm16, 2'b00};
      if (syscall)  return seq;
      else if (jmp) return jaddr;
      else if (br)  return seq + offs;
      else          return seq;
   endfunction

endpackage

// File: rtl/pc_step_unit_rise_detect.sv
// Rising-edge detector for the step-enable level; powers up as if the level
// were already high so a level held across reset does not look like an edge.
module rise_detect
   import pc_step_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic level_q;
   logic level_d;

   always_comb begin
      level_d = level;
   end

   always_ff @(posedge clk) begin
      if (rst) level_q <= 1'b1;
      else     level_q <= level_d;
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/pc_step_unit.sv
// Single-step program counter: one PC commit per cpu_clk rising edge, halts on
// syscall. Optional retired-instruction counter enabled by RETIRE_COUNT_EN.
module pc_step_unit
   import pc_step_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_clk,
   input  logic [31:0] instruction,
   input  logic        branch_success,
   input  logic        jump,
   input  logic [31:0] jump_address,
`ifdef RETIRE_COUNT_EN
   output logic [15:0] retired,
`endif
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic        halted,
   output logic        misalign_err
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pc_valid_q, pc_valid_d;
   logic        halted_q, halted_d;
   logic        mis_q, mis_d;
   logic [31:0] instr_q, instr_d;
   logic        br_q, br_d;
   logic        jmp_q, jmp_d;
   logic [31:0] jaddr_q, jaddr_d;
   logic [31:0] tgt;
   logic        is_syscall;
   logic        rise;

   rise_detect u_rise (
      .clk   (clk),
      .rst   (rst),
      .level (cpu_clk),
      .rise  (rise)
   );

   assign is_syscall = (instr_q == SYSCALL_WORD);
   assign tgt        = next_pc(pc_q, is_syscall, instr_q[15:0], br_q, jmp_q, jaddr_q);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_valid_d = 1'b0;
      halted_d   = halted_q;
      mis_d      = mis_q;
      instr_d    = instr_q;
      br_d       = br_q;
      jmp_d      = jmp_q;
      jaddr_d    = jaddr_q;
      case (state_q)
         ST_RUN: begin
            if (rise) begin
               instr_d = instruction;
               br_d    = branch_success;
               jmp_d   = jump;
               jaddr_d = jump_address;
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            pc_d       = tgt;
            pc_valid_d = 1'b1;
            if (tgt[1:0] != 2'b00) mis_d = 1'b1;
            if (is_syscall) begin
               halted_d = 1'b1;
               state_d  = ST_HALTED;
            end else begin
               state_d  = ST_WAIT_LOW;
            end
         end
         // Edges arriving here belong to the step already taken.
         ST_WAIT_LOW: begin
            if (!cpu_clk) state_d = ST_RUN;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_VECTOR;
         pc_valid_q <= 1'b0;
         halted_q   <= 1'b0;
         mis_q      <= 1'b0;
         instr_q    <= '0;
         br_q       <= 1'b0;
         jmp_q      <= 1'b0;
         jaddr_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         halted_q   <= halted_d;
         mis_q      <= mis_d;
         instr_q    <= instr_d;
         br_q       <= br_d;
         jmp_q      <= jmp_d;
         jaddr_q    <= jaddr_d;
      end
   end

`ifdef RETIRE_COUNT_EN
   logic [15:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if (state_q == ST_COMMIT) retired_d = retired_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) retired_q <= '0;
      else     retired_q <= retired_d;
   end

   assign retired = retired_q;
`endif

   assign pc           = pc_q;
   assign pc_valid     = pc_valid_q;
   assign halted       = halted_q;
   assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_step_unit.sv
// Self-checking bench for pc_step_unit: directed table, corner sequences and
// randomized steps against a step-level reference model.
module tb_pc_step_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_clk;
   logic [31:0] instruction;
   logic        branch_success;
   logic        jump;
   logic [31:0] jump_address;
   logic [31:0] pc;
   logic        pc_valid;
   logic        halted;
   logic        misalign_err;
`ifdef RETIRE_COUNT_EN
   logic [15:0] retired;
`endif

   pc_step_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_clk        (cpu_clk),
      .instruction    (instruction),
      .branch_success (branch_success),
      .jump           (jump),
      .jump_address   (jump_address),
`ifdef RETIRE_COUNT_EN
      .retired        (retired),
`endif
      .pc             (pc),
      .pc_valid       (pc_valid),
      .halted         (halted),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] RV = 32'h0000_0000;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] m_pc;
   logic        m_halt;
   logic        m_mis;
   int          m_ret;

   typedef struct {
      logic [31:0] instr;
      logic        br;
      logic        jmp;
      logic [31:0] jaddr;
      logic [31:0] exp_pc;
      logic        exp_mis;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_pc"}, pc, m_pc);
      chk({tag, "_halted"}, 32'(halted), 32'(m_halt));
      chk({tag, "_mis"}, 32'(misalign_err), 32'(m_mis));
`ifdef RETIRE_COUNT_EN
      chk({tag, "_retired"}, 32'(retired), 32'(m_ret & 16'hFFFF));
`endif
   endtask

   task automatic do_reset(input logic lvl);
      cpu_clk = lvl;
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      m_pc = RV; m_halt = 1'b0; m_mis = 1'b0; m_ret = 0;
      cyc();
   endtask

   // One cpu_clk pulse: high for hi cycles (>=2), low for lo cycles (>=1).
   task automatic step(input logic [31:0] ins, input logic br, input logic jmp,
                       input logic [31:0] ja, input int hi, input int lo, input string tag);
      logic [31:0] old_pc;
      logic [31:0] nxt;
      logic signed [31:0] off;
      logic        exp_pulse;
      int          pulses;
      old_pc    = m_pc;
      exp_pulse = !m_halt;
      if (!m_halt) begin
         off = 32'($signed(ins[15:0]));
         if (ins == 32'h0000_000C) nxt = m_pc + 32'd4;
         else if (jmp)             nxt = ja;
         else if (br)              nxt = m_pc + 32'd4 + 32'(off * 4);
         else                      nxt = m_pc + 32'd4;
         m_pc = nxt;
         if (nxt[1:0] != 2'b00) m_mis = 1'b1;
         if (ins == 32'h0000_000C) m_halt = 1'b1;
         m_ret++;
      end
      instruction = ins; branch_success = br; jump = jmp; jump_address = ja;
      cpu_clk = 1'b1;
      pulses = 0;
      for (int c = 0; c < hi + lo; c++) begin
         if (c == hi) cpu_clk = 1'b0;
         cyc();
         if (pulses > 100) break;
         if (pc_valid === 1'b1) pulses++;
         if (c == 0) begin
            chk({tag, "_lat_pc_hold"}, pc, old_pc);
            chk({tag, "_lat_valid0"}, 32'(pc_valid), 32'd0);
            // Inputs are only sampled on the rise; scramble them afterwards.
            instruction = $urandom; branch_success = 1'($urandom);
            jump = 1'($urandom); jump_address = $urandom;
         end
         if (c == 1) begin
            chk({tag, "_lat_valid"}, 32'(pc_valid), 32'(exp_pulse));
            chk({tag, "_lat_pc"}, pc, m_pc);
         end
      end
      chk({tag, "_pulses"}, 32'(pulses), 32'(exp_pulse));
      check_state(tag);
   endtask

   initial begin
      tbl[0] = '{32'h2008_0005, 1'b0, 1'b0, 32'h0,          32'h0000_0004, 1'b0};
      tbl[1] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0,          32'h0000_0008, 1'b0};
      tbl[2] = '{32'h1000_FFFE, 1'b1, 1'b0, 32'h0,          32'h0000_0004, 1'b0};
      tbl[3] = '{32'h0000_0000, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0};
      tbl[4] = '{32'h1000_0003, 1'b1, 1'b0, 32'h0,          32'h0000_0050, 1'b0};
      tbl[5] = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0042, 32'h0000_0042, 1'b1};
      tbl[6] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0,          32'h0000_0046, 1'b1};
      tbl[7] = '{32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
      tbl[8] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0,          32'h0000_0000, 1'b1};
      tbl[9] = '{32'h1000_7FFF, 1'b1, 1'b0, 32'h0,          32'h0002_0000, 1'b1};

      instruction = '0; branch_success = 1'b0; jump = 1'b0; jump_address = '0;
      cpu_clk = 1'b1;
      rst = 1'b1;
      cyc(); cyc(); cyc();
      m_pc = RV; m_halt = 1'b0; m_mis = 1'b0; m_ret = 0;
      chk("reset_pc", pc, RV);
      chk("reset_valid", 32'(pc_valid), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);
      chk("reset_mis", 32'(misalign_err), 32'd0);

      // cpu_clk already high at reset release must not step
      begin
         int p = 0;
         rst = 1'b0;
         for (int c = 0; c < 6; c++) begin
            cyc();
            if (pc_valid === 1'b1) p++;
         end
         chk("hi_at_release_pulses", 32'(p), 32'd0);
         check_state("hi_at_release");
      end
      cpu_clk = 1'b0;
      cyc(); cyc();

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].instr, tbl[i].br, tbl[i].jmp, tbl[i].jaddr, 2 + (i % 3), 1 + (i % 2), "tbl");
         chk("tbl_exp_pc", pc, tbl[i].exp_pc);
         chk("tbl_exp_mis", 32'(misalign_err), 32'(tbl[i].exp_mis));
      end

      // long high period gives one step; low-then-high gives the next
      do_reset(1'b0);
      step(32'h0, 1'b0, 1'b0, 32'h0, 20, 2, "long_hi");
      chk("long_hi_pc", pc, 32'h4);
      step(32'h0, 1'b0, 1'b0, 32'h0, 2, 1, "second");
      chk("second_pc", pc, 32'h8);
      step(32'h0, 1'b0, 1'b0, 32'h0, 3, 2, "seq");
      step(32'h0, 1'b0, 1'b0, 32'h0, 3, 2, "seq");
      chk("pre_syscall_pc", pc, 32'h10);
      step(32'h0000_000C, 1'b1, 1'b1, 32'h100, 3, 2, "syscall");
      chk("syscall_pc", pc, 32'h14);
      chk("syscall_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 3; i++)
         step(32'h0, 1'b0, 1'b1, 32'h200, 2, 2, "halted");
      chk("halted_pc", pc, 32'h14);
      do_reset(1'b0);
      chk("post_halt_reset_pc", pc, RV);
      chk("post_halt_reset_halted", 32'(halted), 32'd0);

      // reset during COMMIT with cpu_clk held high aborts the step
      step(32'h0, 1'b0, 1'b0, 32'h0, 2, 1, "pre_abort");
      instruction = 32'h0; jump = 1'b1; jump_address = 32'h80; branch_success = 1'b0;
      cpu_clk = 1'b1;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      m_pc = RV; m_halt = 1'b0; m_mis = 1'b0; m_ret = 0;
      chk("abort_pc", pc, RV);
      chk("abort_valid", 32'(pc_valid), 32'd0);
      begin
         int p = 0;
         for (int c = 0; c < 6; c++) begin
            cyc();
            if (pc_valid === 1'b1) p++;
         end
         chk("abort_no_step", 32'(p), 32'd0);
         check_state("abort");
      end
      cpu_clk = 1'b0;
      cyc(); cyc();
      step(32'h0, 1'b0, 1'b0, 32'h0, 2, 1, "after_abort");
      chk("after_abort_pc", pc, 32'h4);

      // randomized steps against the model
      do_reset(1'b0);
      for (int i = 0; i < 60; i++) begin
         logic [31:0] ins, ja;
         logic        br, jmp;
         ins = $urandom;
         if ($urandom_range(0, 39) == 0) ins = 32'h0000_000C;
         br  = ($urandom_range(0, 2) == 0);
         jmp = ($urandom_range(0, 3) == 0);
         ja  = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) ja[1:0] = 2'($urandom_range(1, 3));
         step(ins, br, jmp, ja, int'($urandom_range(2, 6)), int'($urandom_range(1, 4)), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
